// File: rtl/div_iter_param_pkg.sv
// Shared constants for the iterative radix-2 restoring divider: FSM encodings,
// handshake levels and the default operand width.
package div_iter_param_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  typedef logic [2:0] div_state_t;

  localparam div_state_t DIV_FREE   = 3'd0;
  localparam div_state_t DIV_BYZERO = 3'd1;
  localparam div_state_t DIV_ON     = 3'd2;
  localparam div_state_t DIV_FIXUP  = 3'd3;
  localparam div_state_t DIV_END    = 3'd4;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_iter_param_clz.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
// Used by div_iter_param only when DIV_EARLY_OUT_EN is defined.
module div_clz #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  logic found;

  always_comb begin
    count_o = CNT_W'(WIDTH);
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = CNT_W'(WIDTH - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Parametrised iterative radix-2 restoring divider returning {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to skip the dividend's leading zeros (shorter latency).
module div_iter_param
  import div_iter_param_pkg::*;
#(
  parameter int  WIDTH = DIV_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               busy_o
);

  // Handshake: start_i is held high until the requester has consumed the
  // result; ready_o stays high in END while start_i=1, and dropping start_i
  // returns the unit to FREE. annul_i overrides start_i in every state.

  div_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    bmag_q, bmag_d;
  logic                sgn_q, sgn_d;
  logic                dz_q, dz_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;
  logic                dzo_q, dzo_d;

  logic [WIDTH-1:0]    abs_a, abs_b;
  logic [CNT_W-1:0]    lz;
  logic [WIDTH:0]      prem_shift;
  logic [WIDTH+1:0]    trial;
  logic                unused_bits;

  assign abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  div_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
    .data_i  (abs_a),
    .count_o (lz)
  );
`else
  assign lz = '0;
`endif

  // The shifted remainder keeps one extra bit so divisors above 2^(WIDTH-1)
  // (unsigned) still compare correctly; the extra MSB of trial is its sign.
  assign prem_shift  = {rem_q, quo_q[WIDTH-1]};
  assign trial       = {1'b0, prem_shift} - {2'b00, bmag_q};
  assign unused_bits = &{1'b0, trial[WIDTH], prem_shift[WIDTH]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    sgn_d    = sgn_q;
    dz_d     = dz_q;
    result_d = result_q;
    ready_d  = ready_q;
    dzo_d    = dzo_q;

    if (annul_i && state_q != DIV_FREE) begin
      state_d  = DIV_FREE;
      ready_d  = DivResultNotReady;
      result_d = '0;
      dzo_d    = 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready_d  = DivResultNotReady;
          result_d = '0;
          dzo_d    = 1'b0;
          if (start_i == DivStart && !annul_i) begin
            sgn_d = signed_div_i;
            dz_d  = 1'b0;
            if (opdata2_i == '0) begin
              state_d = DIV_BYZERO;
            end else begin
              bmag_d  = abs_b;
              rem_d   = '0;
              cnt_d   = lz;
              quo_d   = abs_a << lz;
`ifdef DIV_EARLY_OUT_EN
              state_d = (lz == CNT_W'(WIDTH)) ? DIV_FIXUP : DIV_ON;
`else
              state_d = DIV_ON;
`endif
            end
          end
        end
        DIV_ON: begin
          if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = prem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_FIXUP;
          end
        end
        DIV_FIXUP: begin
          // Operand MSBs are re-read here; the requester holds them stable.
          if (sgn_q && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1])) begin
            quo_d = -quo_q;
          end
          if (sgn_q && opdata1_i[WIDTH-1]) begin
            rem_d = -rem_q;
          end
          state_d = DIV_END;
        end
        DIV_BYZERO: begin
          quo_d   = '0;
          rem_d   = '0;
          dz_d    = 1'b1;
          state_d = DIV_END;
        end
        DIV_END: begin
          if (start_i == DivStart) begin
            ready_d  = DivResultReady;
            result_d = {rem_q, quo_q};
            dzo_d    = dz_q;
          end else begin
            ready_d  = DivResultNotReady;
            result_d = '0;
            dzo_d    = 1'b0;
            state_d  = DIV_FREE;
          end
        end
        default: begin
          state_d  = DIV_FREE;
          ready_d  = DivResultNotReady;
          result_d = '0;
          dzo_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      sgn_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      sgn_q    <= sgn_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dzo_q    <= dzo_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = dzo_q;
  assign busy_o     = (state_q != DIV_FREE);

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param (WIDTH=32); expected latencies follow
// whether DIV_EARLY_OUT_EN is defined for the build.
module tb_div_iter_param;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           div_zero_o;
  logic           busy_o;

  int tests  = 0;
  int failed = 0;

  logic [2*W:0] exp_q[$];
  logic         prev_ready;

  div_iter_param #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .div_zero_o   (div_zero_o),
    .busy_o       (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pops an expected {div_zero, result} on every rising ready_o
  always @(negedge clk) begin
    if (rst) begin
      prev_ready <= 1'b0;
    end else begin
      if (ready_o && !prev_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_ready: got result=%h dz=%0b, no result expected", result_o, div_zero_o);
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          if ({div_zero_o, result_o} !== e) begin
            failed++;
            $display("FAIL result: got dz=%0b result=%h, expected dz=%0b result=%h",
                     div_zero_o, result_o, e[2*W], e[2*W-1:0]);
          end
        end
      end
      prev_ready <= ready_o;
    end
  end

  task automatic check(input string name, input logic [2*W+2:0] got, input logic [2*W+2:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] erem, input logic [W-1:0] equo,
                         input logic edz, input int lat_off, input int lat_on);
    int exp_lat;
    int lat;
    logic got;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = lat_on;
`else
    exp_lat = lat_off;
`endif
    exp_q.push_back({edz, erem, equo});
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready_o) got = 1'b1;
    end
    check($sformatf("latency %h/%h", a, b), (2*W+3)'(got ? lat : -1), (2*W+3)'(exp_lat));
    @(posedge clk);
    #1;
    check($sformatf("hold %h/%h", a, b), {ready_o, div_zero_o, result_o}, {1'b1, edz, erem, equo});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("drop %h/%h", a, b), {ready_o, div_zero_o, busy_o, result_o}, '0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset_outputs", {ready_o, div_zero_o, busy_o, result_o}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //      sg    a             b             rem           quo           dz  off lat_on
    run_div(1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       0,  34, 9);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0,  34, 5);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0,  34, 5);
    run_div(1'b0, 32'd123,      32'd0,        32'd0,        32'd0,        1,  2,  2);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0,  34, 34);
    run_div(1'b0, 32'd5,        32'd3,        32'd2,        32'd1,        0,  34, 5);
    run_div(1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        0,  34, 2);
    run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        0,  34, 34);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0,  34, 34);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 0,  34, 9);
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       0,  34, 9);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 0,  34, 34);

    // annul mid-iteration: no result may appear
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFF0000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_annul", {31'd0, busy_o}, 1);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_outputs", {ready_o, div_zero_o, busy_o, result_o}, '0);
    @(negedge clk);
    annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_stays_idle", {ready_o, busy_o}, '0);
    run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0, 34, 6);

    // asynchronous reset between clock edges
    @(negedge clk);
    opdata1_i = 32'hFFFF0000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {ready_o, div_zero_o, busy_o, result_o}, '0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, 9);

    repeat (3) @(posedge clk);
    check("queue_drained", (2*W+3)'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
